usb_tx_scheduler: RTL and testbench
===================================

Name: usb_tx_scheduler

Overview:
- Sequences the USB TX packet FSM and shares it between two requesters: the protocol handshake path (ACK/NAK/STALL) and the endpoint data path (DATA0).
- Presents one PID at a time on the TX FSM's 4-bit packet-select input.
- Tracks the FSM's transfer-active/error outputs, then returns per-requester done/error pulses.
- Sits between the RX/protocol logic and buffer control on one side and the TX FSM on the other.

Parameters:
- START_TIMEOUT, 8: max cycles in ISSUE waiting for tx_transfer_active to rise.
- BUSY_TIMEOUT, 1024: max cycles in BUSY waiting for tx_transfer_active to fall.
- STARVE_LIMIT, 3: consecutive handshake grants allowed while data_req is pending before data is forced.

Ports:
- clk  in  1  system clock
- n_rst  in  1  async active-low reset
- hs_req  in  1  handshake request; held until hs_done or hs_err
- hs_pid  in  4  handshake PID; sampled at grant
- data_req  in  1  DATA0 request; held until data_done or data_err
- tx_transfer_active  in  1  from TX FSM
- tx_error  in  1  from TX FSM
- tx_packet  out  4  PID to TX FSM; 4'b0000 = none
- hs_done  out  1  1-cycle pulse: handshake sent
- hs_err  out  1  1-cycle pulse: handshake rejected or failed
- data_done  out  1  1-cycle pulse: data packet sent
- data_err  out  1  1-cycle pulse: data packet failed
- sched_busy  out  1  high in any state except IDLE
- grant_is_data  out  1  owner of current transfer (0 = hs, 1 = data); valid while sched_busy

Behaviour:
- Reset values:
  - All outputs 0; tx_packet = 4'b0000.
  - State IDLE; timer 0; starve counter 0.
  - Async reset mid-transfer returns to IDLE immediately; no done or err pulse is emitted.
- States: IDLE, ISSUE, BUSY, DONE, FAIL. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Arbitration: hs_req wins over data_req, unless starve counter == STARVE_LIMIT and data_req is set; then data wins.
  - hs grant with hs_pid not in {0010, 1010, 1110}: go to FAIL with owner = hs. tx_packet stays 0000.
  - Valid grant: latch PID (data = 0011) and owner, set tx_packet = PID next cycle, clear timer, go to ISSUE.
  - Starve counter:
    - Increments on an hs grant while data_req = 1, saturating at STARVE_LIMIT.
    - Clears on a data grant, or when data_req = 0 at arbitration.
- ISSUE:
  - tx_packet is held at the PID and the timer increments.
  - tx_transfer_active = 1: tx_packet <= 0000, timer cleared, go to BUSY.
  - Otherwise, tx_error = 1 or timer reaches START_TIMEOUT−1: tx_packet <= 0000, go to FAIL.
  - Active takes priority when it coincides with error or timeout.
  - Nominal latency from tx_packet valid to active is 2 cycles.
- BUSY:
  - tx_transfer_active = 0: go to DONE.
  - Timer reaches BUSY_TIMEOUT−1: go to FAIL.
  - tx_error is ignored in this state.
- DONE: one cycle; pulse hs_done or data_done per owner; go to IDLE.
- FAIL: one cycle; pulse hs_err or data_err per owner; go to IDLE.
- Latency:
  - Grant to first tx_packet ≠ 0 is 1 cycle.
  - Minimum IDLE-to-IDLE for an ACK is the TX FSM duration + 3 cycles.
- Requests arriving while sched_busy = 1 wait; they are not queued beyond the held req level.
- A requester dropping req mid-transfer does not abort; its done/err pulse still fires.
- Back-to-back: the next grant is evaluated in the IDLE cycle after DONE/FAIL. tx_packet always shows ≥ 1 cycle of 0000 between packets.
- hs_pid is sampled only at grant; later changes are ignored.

Test Plan:
1. Reset, then hs_req = 1, hs_pid = 0010; model FSM raises active 2 cycles after tx_packet, drops it 10 cycles later. Required: tx_packet = 0010 for 2 cycles then 0000, one hs_done pulse, sched_busy back to 0.
2. hs_req and data_req asserted together, hs held for 4 transfers. Required grant order: hs, hs, hs, data, hs. Only data_done at the 4th completion.
3. hs_pid = 0011 (invalid for hs). Required: FAIL the cycle after grant, one hs_err pulse, tx_packet never leaves 0000.
4. data_req = 1, FSM never raises active. Required: tx_packet = 0011 for exactly 8 cycles, data_err pulse, return to IDLE.
5. tx_error asserted 1 cycle after tx_packet = 1010. Required: hs_err pulse, no hs_done. Also check the coincidence case: tx_error and active in the same cycle gives BUSY.
6. n_rst low while in BUSY. Required: all outputs 0 asynchronously and no pulses; after release, a still-held data_req is re-granted with tx_packet = 0011.

Source files
------------

// File: rtl/usb_tx_scheduler_if.sv
// rtl/usb_tx_scheduler_if.sv - requester / TX FSM signal bundle for the USB TX scheduler
interface usb_tx_scheduler_if;
    logic       hs_req;
    logic [3:0] hs_pid;
    logic       data_req;
    logic       tx_transfer_active;
    logic       tx_error;
    logic [3:0] tx_packet;
    logic       hs_done;
    logic       hs_err;
    logic       data_done;
    logic       data_err;
    logic       sched_busy;
    logic       grant_is_data;

    // Requesters and TX FSM side: drive requests/status, observe scheduler outputs.
    modport master (
        output hs_req, hs_pid, data_req, tx_transfer_active, tx_error,
        input  tx_packet, hs_done, hs_err, data_done, data_err, sched_busy, grant_is_data
    );

    // Scheduler side.
    modport slave (
        input  hs_req, hs_pid, data_req, tx_transfer_active, tx_error,
        output tx_packet, hs_done, hs_err, data_done, data_err, sched_busy, grant_is_data
    );
endinterface

// File: rtl/usb_tx_scheduler.sv
// rtl/usb_tx_scheduler.sv - arbitrates handshake and DATA0 requests onto the USB TX packet FSM
module usb_tx_scheduler #(
    parameter int START_TIMEOUT = 8,
    parameter int BUSY_TIMEOUT  = 1024,
    parameter int STARVE_LIMIT  = 3
) (
    input  logic               clk,
    input  logic               n_rst,
    usb_tx_scheduler_if.slave  bus
);
    localparam int TMAX = (BUSY_TIMEOUT > START_TIMEOUT) ? BUSY_TIMEOUT : START_TIMEOUT;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam int SW   = $clog2(STARVE_LIMIT + 1);

    localparam logic [3:0] PID_NONE  = 4'b0000;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_DONE,
        S_FAIL
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [SW-1:0]   starve_cnt;

    logic            starve_full;
    logic            pick_any;
    logic            pick_data;
    logic            hs_pid_ok;

    // Arbitration decision for the IDLE cycle: handshakes win unless data has been starved.
    always_comb begin
        starve_full = (starve_cnt == SW'(STARVE_LIMIT));
        pick_any    = bus.hs_req || bus.data_req;
        pick_data   = bus.data_req && (!bus.hs_req || starve_full);
        hs_pid_ok   = (bus.hs_pid == PID_ACK) || (bus.hs_pid == PID_NAK) ||
                      (bus.hs_pid == PID_STALL);
    end

    // Scheduler FSM; every output is a register so the TX FSM never sees combinational glitches.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state             <= S_IDLE;
            timer             <= '0;
            starve_cnt        <= '0;
            bus.tx_packet     <= PID_NONE;
            bus.hs_done       <= 1'b0;
            bus.hs_err        <= 1'b0;
            bus.data_done     <= 1'b0;
            bus.data_err      <= 1'b0;
            bus.sched_busy    <= 1'b0;
            bus.grant_is_data <= 1'b0;
        end else begin
            bus.hs_done   <= 1'b0;
            bus.hs_err    <= 1'b0;
            bus.data_done <= 1'b0;
            bus.data_err  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        bus.sched_busy    <= 1'b1;
                        bus.grant_is_data <= pick_data;
                        timer             <= '0;

                        // Count handshake wins that jumped a waiting data request.
                        if (pick_data || !bus.data_req) begin
                            starve_cnt <= '0;
                        end else if (!starve_full) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end

                        if (pick_data) begin
                            bus.tx_packet <= PID_DATA0;
                            state         <= S_ISSUE;
                        end else if (hs_pid_ok) begin
                            bus.tx_packet <= bus.hs_pid;
                            state         <= S_ISSUE;
                        end else begin
                            // Not a handshake PID: reject without touching the TX FSM.
                            bus.hs_err <= 1'b1;
                            state      <= S_FAIL;
                        end
                    end
                end

                S_ISSUE: begin
                    timer <= timer + TW'(1);
                    if (bus.tx_transfer_active) begin
                        bus.tx_packet <= PID_NONE;
                        timer         <= '0;
                        state         <= S_BUSY;
                    end else if (bus.tx_error || (timer == TW'(START_TIMEOUT - 1))) begin
                        bus.tx_packet <= PID_NONE;
                        bus.hs_err    <= !bus.grant_is_data;
                        bus.data_err  <= bus.grant_is_data;
                        state         <= S_FAIL;
                    end
                end

                S_BUSY: begin
                    timer <= timer + TW'(1);
                    if (!bus.tx_transfer_active) begin
                        bus.hs_done   <= !bus.grant_is_data;
                        bus.data_done <= bus.grant_is_data;
                        state         <= S_DONE;
                    end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
                        bus.hs_err    <= !bus.grant_is_data;
                        bus.data_err  <= bus.grant_is_data;
                        state         <= S_FAIL;
                    end
                end

                // Pulse cycle; the next grant is evaluated in the following IDLE cycle.
                S_DONE, S_FAIL: begin
                    bus.sched_busy <= 1'b0;
                    state          <= S_IDLE;
                end

                default: begin
                    bus.tx_packet  <= PID_NONE;
                    bus.sched_busy <= 1'b0;
                    state          <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_usb_tx_scheduler.sv
// tb/tb_usb_tx_scheduler.sv - self-checking bench for usb_tx_scheduler
module tb_usb_tx_scheduler;
    localparam int START_TIMEOUT = 8;
    localparam int BUSY_TIMEOUT  = 1024;
    localparam int STARVE_LIMIT  = 3;

    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;

    logic clk = 1'b0;
    logic n_rst;

    always #5 clk = ~clk;

    usb_tx_scheduler_if bus();

    usb_tx_scheduler #(
        .START_TIMEOUT (START_TIMEOUT),
        .BUSY_TIMEOUT  (BUSY_TIMEOUT),
        .STARVE_LIMIT  (STARVE_LIMIT)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: outstanding requests and data starvation count.
    bit hs_pend   = 1'b0;
    bit data_pend = 1'b0;
    int starve    = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int out_word();
        return int'({bus.tx_packet, bus.hs_done, bus.hs_err, bus.data_done,
                     bus.data_err, bus.sched_busy, bus.grant_is_data});
    endfunction

    // One scheduled transfer. The bench plays the TX FSM: active rises so that it is
    // seen at the end of issue cycle act_at (0 = never), stays up blen more cycles;
    // tx_error pulses in cycle err_at (0 = never). Cycle 1 is the first busy cycle.
    task automatic run_xfer(input bit new_hs, input logic [3:0] pid, input bit new_data,
                            input int act_at, input int err_at, input int blen,
                            input bit busy_err, input bit drop_early, input bit pid_chg,
                            input int rst_at);
        bit         win_data, invalid, busy_path, ok_done;
        int         p, t, first_end, bl;
        logic [3:0] exp_pid;
        int         pkt_bad = 0;
        int         n_hsd = 0, n_hse = 0, n_dd = 0, n_de = 0;
        int         hit_t = 0;

        bus.tx_transfer_active = 1'b0;
        bus.tx_error           = 1'b0;
        hs_pend   |= new_hs;
        data_pend |= new_data;
        bus.hs_req   = hs_pend;
        bus.data_req = data_pend;
        bus.hs_pid   = pid;

        win_data = data_pend && (!hs_pend || starve == STARVE_LIMIT);
        if (win_data || !data_pend) starve = 0;
        else if (starve < STARVE_LIMIT) starve++;

        exp_pid = win_data ? PID_DATA0 : pid;
        invalid = !win_data && !(pid inside {PID_ACK, PID_NAK, PID_STALL});

        if (invalid) begin
            p = 0; busy_path = 0; ok_done = 0; t = 1;
        end else begin
            first_end = START_TIMEOUT;
            if (err_at > 0 && err_at < first_end) first_end = err_at;
            if (act_at > 0 && act_at <= first_end) begin
                busy_path = 1;
                p         = act_at;
                bl        = (blen < BUSY_TIMEOUT) ? blen + 1 : BUSY_TIMEOUT;
                ok_done   = (blen < BUSY_TIMEOUT);
                t         = p + bl + 1;
            end else begin
                busy_path = 0; p = first_end; ok_done = 0; t = p + 1;
            end
        end

        for (int c = 1; c <= t + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check_eq("busy_at_grant", int'(bus.sched_busy), 1);
                check_eq("owner", int'(bus.grant_is_data), int'(win_data));
            end
            if (c <= t && bus.tx_packet != ((c <= p) ? exp_pid : 4'b0000)) pkt_bad++;
            n_hsd += int'(bus.hs_done);
            n_hse += int'(bus.hs_err);
            n_dd  += int'(bus.data_done);
            n_de  += int'(bus.data_err);
            if (c == t)
                hit_t = win_data ? int'(ok_done ? bus.data_done : bus.data_err)
                                 : int'(ok_done ? bus.hs_done : bus.hs_err);
            if (rst_at != 0 && c == rst_at) begin
                n_rst = 1'b0;
                #1;
                check_eq("rst_async_outputs", out_word(), 0);
                bus.tx_transfer_active = 1'b0;
                bus.tx_error           = 1'b0;
                @(posedge clk);
                #1;
                check_eq("rst_held_outputs", out_word(), 0);
                @(negedge clk);
                n_rst  = 1'b1;
                starve = 0;
                return;
            end
            if (c == t + 1) begin
                check_eq("idle_after", int'(bus.sched_busy), 0);
                break;
            end
            bus.tx_transfer_active = busy_path && c >= act_at && c <= act_at + blen;
            bus.tx_error = (c == err_at) || (busy_err && busy_path && c == act_at + 1);
            if (drop_early && c == 1) begin
                if (win_data) bus.data_req = 1'b0;
                else          bus.hs_req   = 1'b0;
            end
            if (pid_chg && c == 1) bus.hs_pid = 4'($urandom);
            if (c == t) begin
                if (win_data) begin data_pend = 1'b0; bus.data_req = 1'b0; end
                else          begin hs_pend   = 1'b0; bus.hs_req   = 1'b0; end
            end
        end

        bus.tx_transfer_active = 1'b0;
        bus.tx_error           = 1'b0;
        check_eq("tx_packet_bad_cycles", pkt_bad, 0);
        check_eq("pulse_at_end", hit_t, 1);
        check_eq("hs_done_count",   n_hsd, (!win_data &&  ok_done) ? 1 : 0);
        check_eq("hs_err_count",    n_hse, (!win_data && !ok_done) ? 1 : 0);
        check_eq("data_done_count", n_dd,  ( win_data &&  ok_done) ? 1 : 0);
        check_eq("data_err_count",  n_de,  ( win_data && !ok_done) ? 1 : 0);
    endtask

    initial begin
        logic [3:0] pids [3];
        logic [3:0] rpid;
        bit         nh, nd;
        int         ea;

        pids[0] = PID_ACK; pids[1] = PID_NAK; pids[2] = PID_STALL;

        n_rst                  = 1'b0;
        bus.hs_req             = 1'b0;
        bus.hs_pid             = 4'b0000;
        bus.data_req           = 1'b0;
        bus.tx_transfer_active = 1'b0;
        bus.tx_error           = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", out_word(), 0);
        n_rst = 1'b1;

        // Plain ACK.
        run_xfer(1, PID_ACK, 0, 2, 0, 10, 0, 0, 0, 0);
        // Starvation: hs, hs, hs, data, hs.
        run_xfer(1, PID_ACK,   1, 2, 0, 4, 0, 0, 0, 0);
        run_xfer(1, PID_NAK,   0, 2, 0, 4, 0, 0, 0, 0);
        run_xfer(1, PID_STALL, 0, 2, 0, 4, 0, 0, 0, 0);
        run_xfer(1, PID_ACK,   0, 2, 0, 4, 0, 0, 0, 0);
        run_xfer(0, PID_ACK,   0, 2, 0, 4, 0, 0, 0, 0);
        // Invalid handshake PID.
        run_xfer(1, 4'b0011, 0, 2, 0, 4, 0, 0, 0, 0);
        // Start timeout on data.
        run_xfer(0, PID_ACK, 1, 0, 0, 0, 0, 0, 0, 0);
        // TX error during issue, then error coinciding with active (plus ignored busy error).
        run_xfer(1, PID_NAK, 0, 0, 2, 0, 0, 0, 0, 0);
        run_xfer(1, PID_NAK, 0, 2, 2, 5, 1, 0, 0, 0);
        // Reset in BUSY, then re-grant of the still-held data request.
        run_xfer(0, PID_ACK, 1, 2, 0, 20, 0, 0, 0, 5);
        run_xfer(0, PID_ACK, 0, 2, 0, 3, 0, 0, 0, 0);
        // Busy timeout boundary: just in time, then one cycle too long.
        run_xfer(0, PID_ACK,   1, 2, 0, BUSY_TIMEOUT - 1, 0, 0, 0, 0);
        run_xfer(1, PID_STALL, 0, 1, 0, BUSY_TIMEOUT,     0, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            nh = 1'($urandom);
            nd = 1'($urandom);
            if (!nh && !nd && !hs_pend && !data_pend) nh = 1'b1;
            rpid = ($urandom_range(0, 4) == 0) ? 4'($urandom) : pids[$urandom_range(0, 2)];
            ea   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 9)) : 0;
            run_xfer(nh, rpid, nd, int'($urandom_range(1, 10)), ea,
                     int'($urandom_range(0, 11)), 1'($urandom), 1'($urandom),
                     1'($urandom), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
